fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo_single_clk write port between N_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST words.
- Throttles on FIFO occupancy and drives the FIFO's wr_en/buf_in from registers.
- Sits directly in front of the FIFO, same clock domain; FIFO read side is untouched.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, data width, matches FIFO buf_in
CW, 8, width of FIFO fifo_counter
DEPTH, 64, FIFO capacity in words
MAX_BURST, 8, max words accepted per grant (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low; sampled on rising clk
req  in  N_REQ  per-requester "word valid"; must hold with data until acked
req_data  in  N_REQ*DW  flattened data; requester i at [i*DW +: DW]
fifo_counter  in  CW  occupancy from FIFO
gnt  out  N_REQ  registered one-hot grant (all-zero when idle)
ack  out  N_REQ  combinational; word accepted this cycle
fifo_wr_en  out  1  registered write strobe to FIFO
fifo_buf_in  out  DW  registered write data to FIFO
busy  out  1  high while state is BURST

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; gnt=0; fifo_wr_en=0; fifo_buf_in=0; burst_cnt=0; last_idx=N_REQ-1, so requester 0 has first priority.
- Space check:
  - space_ok = (fifo_counter + fifo_wr_en) < DEPTH, evaluated at CW+1 bits.
  - The in-flight registered write is counted, so the FIFO is never written while full.
  - FIFO reads are ignored (conservative).
- Acceptance: ack[i] = (state==BURST) & gnt[i] & req[i] & space_ok. At most one ack bit is high.
- Write path: on an accepted cycle, the next edge sets fifo_wr_en=1 and fifo_buf_in=req_data[g]. Otherwise fifo_wr_en=0 and fifo_buf_in holds. Latency from ack to FIFO write strobe is 1 cycle.
- FSM IDLE:
  - If any req is set, pick the first set bit scanning last_idx+1, last_idx+2, ... (mod N_REQ).
  - Set gnt to that one-hot, burst_cnt=0, go to BURST.
  - No ack is possible in the grant cycle.
- FSM BURST:
  - On each ack, burst_cnt increments.
  - Go to IDLE (gnt=0, last_idx=granted index) when either:
    - req[g]=0 (requester released), or
    - an ack occurs with burst_cnt==MAX_BURST-1.
  - Stalled by !space_ok: stay in BURST, hold gnt and burst_cnt, no ack.
- Boundary rules:
  - The burst-end cycle is always followed by at least one IDLE cycle before the next grant (fixed 1-cycle re-arbitration gap).
  - A requester dropping req while stalled ends the burst with no word lost.
  - A requester that is never released is preempted after MAX_BURST words; others then get a turn.
  - fifo_counter==DEPTH on entry to BURST: hold until space opens.
  - Reset mid-burst clears everything, including a pending fifo_wr_en. The FIFO shares rst, so no partial state survives.
  - Requests from non-granted requesters are ignored until IDLE.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=1'b0, BURST=1'b1), default DEPTH/DW/CW constants shared with fifo_single_clk.
- One natural sub-module: rr_pick. It is a combinational rotate-priority one-hot selector taking req and last_idx and returning a one-hot and an index.
- Everything else stays in fifo_wr_arbiter.

Test Plan:
- Reset then single requester: req[0] with 11,12,13 held three cycles each until ack. Required: gnt=0001 one cycle after req; fifo_wr_en pulses carry 11,12,13 in order, each 1 cycle after its ack; gnt returns to 0 after req[0] drops.
- Fairness: req[0] and req[2] both held continuously with MAX_BURST=8. Required: grants alternate 0,2,0,2; each burst is exactly 8 acks; exactly one idle cycle between bursts.
- Full throttle: tie fifo_counter=63 and stream from req[1]. Required: one ack, then fifo_wr_en=1 makes space_ok=0, so no further ack; after setting fifo_counter=62 the stream resumes; never more than 64 writes in total with the real FIFO attached.
- Release while stalled: fifo_counter=64, gnt[3] held, then drop req[3]. Required: no ack ever; state returns to IDLE; last_idx=3, so req[0] wins next.
- Reset mid-burst: assert rst=0 for one edge during the 4th word of a burst. Required: gnt=0, fifo_wr_en=0, busy=0 at the next edge; priority restarts at requester 0.
- Scoreboard: four requesters emit random data with random req gaps for 2000 cycles. Required: FIFO contents equal the per-requester order merged in ack order; no ack while fifo_counter+fifo_wr_en>=64.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// The DEPTH/DW/CW defaults match fifo_single_clk.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_DEPTH = 64;
    localparam int DEF_DW    = 8;
    localparam int DEF_CW    = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority one-hot selector.
// Scans from last_idx+1 upward, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_idx,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             found
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last_idx) + k) % N_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Throttles on occupancy plus the in-flight registered write.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = DEF_DW,
    parameter int CW        = DEF_CW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [CW-1:0]       fifo_counter,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                fifo_wr_en,
    output logic [DW-1:0]       fifo_buf_in,
    output logic                busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    arb_state_t     state;
    logic [BW-1:0]  burst_cnt;
    logic [IW-1:0]  last_idx;
    logic [IW-1:0]  g_idx;

    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;

    logic           space_ok;
    logic           req_g;
    logic           accept;
    logic [DW-1:0]  sel_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req      (req),
        .last_idx (last_idx),
        .onehot   (pick_oh),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    // A write registered last cycle has not reached fifo_counter yet.
    assign space_ok = ({1'b0, fifo_counter} + (CW+1)'(fifo_wr_en))
                      < (CW+1)'(DEPTH);

    assign req_g  = |(req & gnt);
    assign ack    = gnt & req & {N_REQ{space_ok && state == BURST}};
    assign accept = |ack;
    assign busy   = (state == BURST);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) sel_data = req_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            gnt         <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_buf_in <= '0;
            burst_cnt   <= '0;
            last_idx    <= IW'(N_REQ - 1);
            g_idx       <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt       <= pick_oh;
                        g_idx     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        fifo_wr_en  <= 1'b1;
                        fifo_buf_in <= sel_data;
                        burst_cnt   <= burst_cnt + 1'b1;
                    end
                    if (!req_g ||
                        (accept && burst_cnt == BW'(MAX_BURST - 1))) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        last_idx <= g_idx;
                    end
                end
            endcase
        end
    end

endmodule
